// File: rtl/bit_stream_serializer_pkg.sv
// rtl/bit_stream_serializer_pkg.sv - shared state encoding and sizing helper for the bit-stream serializer
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits-remaining counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel-to-serial shifter with one-word hold buffer
//
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset
//   load_valid  load_data is valid this cycle
//   load_ready  block can accept a word this cycle
//   load_data   parallel word to serialize
//   bit_out     serial bit, one per clock while bit_valid
//   bit_valid   bit_out carries a real data bit
//   word_done   final bit of a word is on bit_out
//   busy        shifting or hold buffer occupied
module bit_stream_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("bit_stream_serializer: WIDTH must be >= 2");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic [WIDTH-1:0] hold, hold_nx;
    logic             hold_full, hold_full_nx;
    logic [CW-1:0]    cnt, cnt_nx;

    logic             xfer;
    logic             last_bit;
    logic [WIDTH-1:0] sh_shifted;

    assign load_ready = reset_n & ~hold_full;
    assign xfer       = load_valid & load_ready;
    assign last_bit   = (state == ST_SHIFT) && (cnt == CW'(1));

    // Move the next bit toward whichever end drives bit_out, zero-filling behind it.
    assign sh_shifted = LSB_FIRST ? (sh >> 1) : (sh << 1);

    always_comb begin
        state_nx     = state;
        sh_nx        = sh;
        cnt_nx       = cnt;
        hold_nx      = hold;
        hold_full_nx = hold_full;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    sh_nx    = load_data;
                    cnt_nx   = CW'(WIDTH);
                    state_nx = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (last_bit) begin
                    // Reloading on the last-bit edge keeps consecutive words gap-free.
                    // A held word and a new transfer never coincide: load_ready is low
                    // whenever the hold buffer is occupied.
                    if (hold_full) begin
                        sh_nx        = hold;
                        cnt_nx       = CW'(WIDTH);
                        hold_full_nx = 1'b0;
                    end else if (xfer) begin
                        sh_nx  = load_data;
                        cnt_nx = CW'(WIDTH);
                    end else begin
                        sh_nx    = '0;
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    sh_nx  = sh_shifted;
                    cnt_nx = cnt - CW'(1);
                    if (xfer) begin
                        hold_nx      = load_data;
                        hold_full_nx = 1'b1;
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            sh        <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nx;
            sh        <= sh_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
        end
    end

    // Serial outputs come only from registers so a downstream Mealy detector
    // never sees a combinational path from load_valid/load_data.
    assign bit_valid = (state == ST_SHIFT);
    assign bit_out   = bit_valid & (LSB_FIRST ? sh[0] : sh[WIDTH-1]);
    assign word_done = last_bit;
    assign busy      = bit_valid | hold_full;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - randomized self-checking bench for bit_stream_serializer
module tb_bit_stream_serializer;

    localparam int W = 10;

    logic         clock;
    logic         reset_n;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic m_ready, m_bit, m_valid, m_done, m_busy;
    logic l_ready, l_bit, l_valid, l_done, l_busy;

    int checks = 0;
    int errors = 0;

    // Reference: queue of accepted words not yet started, plus the word on the wire.
    logic [W-1:0] wq[$];
    logic [W-1:0] cur;
    int           rem;
    logic [W-1:0] offer[$];

    bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(m_ready),
        .load_data(load_data), .bit_out(m_bit), .bit_valid(m_valid), .word_done(m_done),
        .busy(m_busy)
    );

    bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(l_ready),
        .load_data(load_data), .bit_out(l_bit), .bit_valid(l_valid), .word_done(l_done),
        .busy(l_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        cur = '0;
        rem = 0;
    endtask

    task automatic cycle(input logic lv, input logic [W-1:0] d, input logic rn, output logic took);
        logic exp_ready, exp_msb, exp_lsb;
        @(negedge clock);
        load_valid = lv;
        load_data  = d;
        reset_n    = rn;
        #1;
        exp_ready = rn && (wq.size() == 0);
        exp_msb   = (rem > 0) ? cur[rem-1] : 1'b0;
        exp_lsb   = (rem > 0) ? cur[W-rem] : 1'b0;
        check("msb_ready", 32'(m_ready), 32'(exp_ready));
        check("msb_valid", 32'(m_valid), 32'(rem > 0));
        check("msb_done",  32'(m_done),  32'(rem == 1));
        check("msb_busy",  32'(m_busy),  32'((rem > 0) || (wq.size() > 0)));
        check("msb_bit",   32'(m_bit),   32'(exp_msb));
        check("lsb_ready", 32'(l_ready), 32'(exp_ready));
        check("lsb_valid", 32'(l_valid), 32'(rem > 0));
        check("lsb_done",  32'(l_done),  32'(rem == 1));
        check("lsb_bit",   32'(l_bit),   32'(exp_lsb));
        took = lv && exp_ready;
        @(posedge clock);
        if (!rn) begin
            model_reset();
        end else begin
            if (rem > 0) rem--;
            if (took) wq.push_back(d);
            if (rem == 0 && wq.size() > 0) begin
                cur = wq.pop_front();
                rem = W;
            end
        end
    endtask

    // Offer every word in 'offer' with load_valid held high, then idle for 'tail' cycles.
    task automatic stream(input int tail);
        logic took;
        int   guard;
        guard = 0;
        while (offer.size() > 0 && guard < 200) begin
            cycle(1'b1, offer[0], 1'b1, took);
            if (took) void'(offer.pop_front());
            guard++;
        end
        check("stream_drained", 32'(offer.size()), 32'd0);
        offer.delete();
        for (int i = 0; i < tail; i++) cycle(1'b0, W'($urandom), 1'b1, took);
    endtask

    initial begin
        logic took;
        int   done_cnt;
        int   valid_run;
        load_valid = 1'b0;
        load_data  = '0;
        reset_n    = 1'b0;
        model_reset();

        // Reset for two cycles with garbage offered: nothing may be accepted.
        cycle(1'b1, W'($urandom), 1'b0, took);
        cycle(1'b1, W'($urandom), 1'b0, took);

        // Single word, then back to idle.
        offer.push_back(10'b1110011001);
        stream(14);

        // Back-to-back pair and a backpressured triple; count contiguous valid bits.
        offer.push_back(10'b1110011001);
        offer.push_back(10'b0000011111);
        stream(0);
        offer.push_back(10'b1010101010);
        offer.push_back(10'b0110000001);
        offer.push_back(10'b1111100000);
        done_cnt  = 0;
        valid_run = 0;
        while (offer.size() > 0) begin
            cycle(1'b1, offer[0], 1'b1, took);
            if (took) void'(offer.pop_front());
        end
        while (m_valid) begin
            if (m_done) done_cnt++;
            valid_run++;
            cycle(1'b0, '0, 1'b1, took);
            if (valid_run > 100) break;
        end
        check("triple_tail_done", 32'(done_cnt >= 1), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, took);

        // Reset after four bits with a second word sitting in hold.
        cycle(1'b1, 10'b1110011001, 1'b1, took);
        for (int i = 0; i < 4; i++) cycle(1'b1, 10'b0101010101, 1'b1, took);
        check("hold_occupied", 32'(m_ready), 32'd0);
        cycle(1'b1, 10'b0011001100, 1'b0, took);
        cycle(1'b1, 10'b0011001100, 1'b0, took);
        offer.push_back(10'b1000000001);
        stream(12);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic rn;
            rn = ($urandom_range(0, 99) != 0);
            cycle(($urandom_range(0, 3) != 0), W'($urandom), rn, took);
        end
        for (int i = 0; i < 25; i++) cycle(1'b0, '0, 1'b1, took);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
